// File: rtl/servo_pwm_multi_pkg.sv
// ---------------------------------------------------------------------------
// servo_pwm_multi_pkg
//   Shared types and constant helpers for the multi-channel servo PWM block.
//   The derived constants (SPAN, CENTER, TICK_DIV, US_W) are exposed as
//   constant functions so that every parameterisation of the top level and
//   of the channel slice computes them identically.
// ---------------------------------------------------------------------------
package servo_pwm_multi_pkg;

    // Sweep direction of one channel.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Default parameterisation: 50 MHz clock, 20 ms frame, 1..2 ms pulses.
    localparam int DEF_CLK_HZ    = 50_000_000;
    localparam int DEF_N_CH      = 4;
    localparam int DEF_POS_W     = 10;
    localparam int DEF_PERIOD_US = 20_000;
    localparam int DEF_MIN_US    = 1_000;
    localparam int DEF_MAX_US    = 2_000;
    localparam int DEF_STEP      = 10;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Position range covered by the pulse-width window.
    function automatic int span_of(input int min_us, input int max_us);
        return max_us - min_us;
    endfunction

    // Mid-travel position used at reset.
    function automatic int center_of(input int min_us, input int max_us);
        return (max_us - min_us) / 2;
    endfunction

    // mclk cycles per microsecond tick.
    function automatic int tick_div_of(input int clk_hz);
        return clk_hz / 1_000_000;
    endfunction

    // Width of the frame counter and of the pulse comparator.
    function automatic int us_w_of(input int period_us);
        return clog2(period_us + 1);
    endfunction

endpackage

// File: rtl/servo_pwm_ch.sv
// ---------------------------------------------------------------------------
// servo_pwm_ch
//   One servo channel: target position (host writes or sweep), sweep
//   direction, shadow position loaded only at frame start, and the
//   registered pulse comparator.
// Ports
//   mclk, rst_n   clock, asynchronous active-low reset
//   frame_upd     one-cycle frame-start strobe from the shared counter
//   us_cnt        current microsecond position inside the frame
//   wr_hit        host write addressed to this channel
//   wr_pos        host write data (clamped to SPAN)
//   sweep_en      autonomous sweep enable
//   freeze        hold shadow/direction, suspend sweep stepping
//   pwm           registered pulse output
//   shd           active (shadow) position
// ---------------------------------------------------------------------------
module servo_pwm_ch
    import servo_pwm_multi_pkg::*;
#(
    parameter int POS_W  = DEF_POS_W,
    parameter int US_W   = 15,
    parameter int MIN_US = DEF_MIN_US,
    parameter int MAX_US = DEF_MAX_US,
    parameter int STEP   = DEF_STEP
) (
    input  logic             mclk,
    input  logic             rst_n,
    input  logic             frame_upd,
    input  logic [US_W-1:0]  us_cnt,
    input  logic             wr_hit,
    input  logic [POS_W-1:0] wr_pos,
    input  logic             sweep_en,
    input  logic             freeze,
    output logic             pwm,
    output logic [POS_W-1:0] shd
);

    localparam logic [POS_W-1:0] SPAN_V   = POS_W'(span_of(MIN_US, MAX_US));
    localparam logic [POS_W-1:0] CENTER_V = POS_W'(center_of(MIN_US, MAX_US));
    localparam logic [POS_W:0]   SPAN_X   = (POS_W+1)'(span_of(MIN_US, MAX_US));
    localparam logic [POS_W:0]   STEP_X   = (POS_W+1)'(STEP);
    localparam logic [POS_W-1:0] STEP_V   = POS_W'(STEP);
    localparam logic [US_W-1:0]  MIN_V    = US_W'(MIN_US);

    logic [POS_W-1:0] tgt_r;
    logic [POS_W-1:0] tgt_nxt_s;
    logic [POS_W-1:0] shd_r;
    logic [POS_W-1:0] wr_clamp_s;
    logic [POS_W:0]   up_sum_s;
    logic [US_W-1:0]  limit_s;
    dir_e             dir_r;
    dir_e             dir_nxt_s;
    logic             load_s;
    logic             step_s;
    logic             pwm_r;

    // A frozen channel neither reloads its shadow nor steps its sweep; a
    // same-cycle host write takes priority over the sweep step.
    assign load_s     = frame_upd && !freeze;
    assign step_s     = load_s && sweep_en && !wr_hit;
    assign wr_clamp_s = (wr_pos > SPAN_V) ? SPAN_V : wr_pos;
    // One extra bit so the upward step cannot wrap before the clamp test.
    assign up_sum_s   = {1'b0, tgt_r} + STEP_X;
    // MIN_US + shd never exceeds MAX_US <= PERIOD_US, so US_W bits suffice.
    assign limit_s    = MIN_V + US_W'(shd_r);

    // Next target and direction: write, sweep step with clamp/reverse, or hold.
    always_comb begin
        tgt_nxt_s = tgt_r;
        dir_nxt_s = dir_r;
        if (wr_hit) begin
            tgt_nxt_s = wr_clamp_s;
            dir_nxt_s = dir_r;
        end else if (step_s) begin
            case (dir_r)
                DIR_UP: begin
                    if (up_sum_s >= SPAN_X) begin
                        tgt_nxt_s = SPAN_V;
                        dir_nxt_s = DIR_DOWN;
                    end else begin
                        tgt_nxt_s = up_sum_s[POS_W-1:0];
                        dir_nxt_s = DIR_UP;
                    end
                end
                DIR_DOWN: begin
                    if ({1'b0, tgt_r} <= STEP_X) begin
                        tgt_nxt_s = '0;
                        dir_nxt_s = DIR_UP;
                    end else begin
                        tgt_nxt_s = tgt_r - STEP_V;
                        dir_nxt_s = DIR_DOWN;
                    end
                end
                default: begin
                    tgt_nxt_s = tgt_r;
                    dir_nxt_s = DIR_UP;
                end
            endcase
        end else begin
            tgt_nxt_s = tgt_r;
            dir_nxt_s = dir_r;
        end
    end

    // Target and sweep direction registers.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_r <= CENTER_V;
            dir_r <= DIR_UP;
        end else begin
            tgt_r <= tgt_nxt_s;
            dir_r <= dir_nxt_s;
        end
    end

    // Shadow position: loads the pre-step target only at frame start.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            shd_r <= CENTER_V;
        end else if (load_s) begin
            shd_r <= tgt_r;
        end else begin
            shd_r <= shd_r;
        end
    end

    // Registered pulse comparator.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_r <= 1'b0;
        end else begin
            pwm_r <= (us_cnt < limit_s);
        end
    end

    assign pwm = pwm_r;
    assign shd = shd_r;

endmodule

// File: rtl/servo_pwm_multi.sv
// ---------------------------------------------------------------------------
// servo_pwm_multi
//   N-channel hobby-servo PWM generator. A prescaler derives a 1 us tick
//   from mclk, one shared counter spans the frame, and each channel slice
//   produces its own registered pulse. Position changes take effect only at
//   frame start so a pulse is never cut or stretched mid-flight.
// Ports
//   mclk, rst_n   system clock, asynchronous active-low reset
//   wr_en         one-cycle position write strobe
//   wr_ch         target channel of the write
//   wr_pos        requested position (clamped to SPAN)
//   sweep_en      per-channel autonomous sweep enable
//   freeze        per-channel hold of the current pulse width
//   pwm           per-channel servo pulses, registered
//   frame_start   one-cycle pulse at every frame wrap
//   pos_mon       active (shadow) positions, ch0 in the LSBs
//   wr_err        one-cycle pulse after a write to a nonexistent channel
// ---------------------------------------------------------------------------
module servo_pwm_multi
    import servo_pwm_multi_pkg::*;
#(
    parameter  int CLK_HZ    = DEF_CLK_HZ,
    parameter  int N_CH      = DEF_N_CH,
    parameter  int POS_W     = DEF_POS_W,
    parameter  int PERIOD_US = DEF_PERIOD_US,
    parameter  int MIN_US    = DEF_MIN_US,
    parameter  int MAX_US    = DEF_MAX_US,
    parameter  int STEP      = DEF_STEP,
    localparam int CH_W      = (N_CH > 1) ? clog2(N_CH) : 1
) (
    input  logic                  mclk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [CH_W-1:0]       wr_ch,
    input  logic [POS_W-1:0]      wr_pos,
    input  logic [N_CH-1:0]       sweep_en,
    input  logic [N_CH-1:0]       freeze,
    output logic [N_CH-1:0]       pwm,
    output logic                  frame_start,
    output logic [N_CH*POS_W-1:0] pos_mon,
    output logic                  wr_err
);

    localparam int TICK_DIV = tick_div_of(CLK_HZ);
    localparam int US_W     = us_w_of(PERIOD_US);
    localparam int PS_W     = clog2(TICK_DIV);

    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(TICK_DIV - 1);
    localparam logic [US_W-1:0] US_LAST  = US_W'(PERIOD_US - 1);
    localparam logic [CH_W:0]   N_CH_V   = (CH_W+1)'(N_CH);

    logic [PS_W-1:0] prescaler_r;
    logic [US_W-1:0] us_cnt_r;
    logic            frame_start_r;
    logic            wr_err_r;
    logic            tick_s;
    logic            wrap_s;
    logic            wr_bad_s;

    assign tick_s   = (prescaler_r == PS_LAST);
    assign wrap_s   = tick_s && (us_cnt_r == US_LAST);
    // Extra bit so the range check stays meaningful when N_CH is a power of 2.
    assign wr_bad_s = wr_en && ({1'b0, wr_ch} >= N_CH_V);

    // Microsecond prescaler.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_r <= '0;
        end else if (tick_s) begin
            prescaler_r <= '0;
        end else begin
            prescaler_r <= prescaler_r + 1'b1;
        end
    end

    // Frame counter in microseconds, wrapping at PERIOD_US.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            us_cnt_r <= '0;
        end else if (wrap_s) begin
            us_cnt_r <= '0;
        end else if (tick_s) begin
            us_cnt_r <= us_cnt_r + 1'b1;
        end else begin
            us_cnt_r <= us_cnt_r;
        end
    end

    // Frame-start strobe (first cycle with us_cnt back at 0) and write-error flag.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start_r <= 1'b0;
            wr_err_r      <= 1'b0;
        end else begin
            frame_start_r <= wrap_s;
            wr_err_r      <= wr_bad_s;
        end
    end

    assign frame_start = frame_start_r;
    assign wr_err      = wr_err_r;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic             hit_s;
        logic [POS_W-1:0] shd_s;

        assign hit_s = wr_en && (wr_ch == CH_W'(gi));

        servo_pwm_ch #(
            .POS_W  (POS_W),
            .US_W   (US_W),
            .MIN_US (MIN_US),
            .MAX_US (MAX_US),
            .STEP   (STEP)
        ) u_ch (
            .mclk      (mclk),
            .rst_n     (rst_n),
            .frame_upd (frame_start_r),
            .us_cnt    (us_cnt_r),
            .wr_hit    (hit_s),
            .wr_pos    (wr_pos),
            .sweep_en  (sweep_en[gi]),
            .freeze    (freeze[gi]),
            .pwm       (pwm[gi]),
            .shd       (shd_s)
        );

        assign pos_mon[gi*POS_W +: POS_W] = shd_s;
    end

endmodule
